// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // Widest one-hot vector the index helper accepts.
    localparam int unsigned MAX_SRC = 32;

    function automatic int unsigned onehot_to_idx(input logic [MAX_SRC-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

    // Pointer value that makes source 0 the first winner of the scan.
    function automatic int unsigned rr_reset_ptr(input int unsigned num_src);
        return num_src - 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Source-side handshake bundle and FIFO write-port bundle of the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned SW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]            i_valid_s;
    logic [NUM_SRC-1:0]            i_last_s;
    logic [NUM_SRC*DATA_WIDTH-1:0] i_datain;
    logic [NUM_SRC-1:0]            o_ready_s;
    logic                          o_valid_m;
    logic [DATA_WIDTH-1:0]         o_dataout;
    logic                          i_ready_m;
    logic                          i_almostfull;
    logic [NUM_SRC-1:0]            o_grant;
    logic [SW-1:0]                 o_grant_id;
    logic                          o_busy;

    // Arbiter side.
    modport slave (
        input  i_valid_s, i_last_s, i_datain, i_ready_m, i_almostfull,
        output o_ready_s, o_valid_m, o_dataout, o_grant, o_grant_id, o_busy
    );

    // Environment side: sources plus FIFO.
    modport master (
        output i_valid_s, i_last_s, i_datain, i_ready_m, i_almostfull,
        input  o_ready_s, o_valid_m, o_dataout, o_grant, o_grant_id, o_busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above the pointer, with wrap.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SW-1:0]      ptr_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [SW-1:0]      idx_o,
    output logic               any_o
);

    logic               found;
    logic [SW-1:0]      k;
    logic [MAX_SRC-1:0] gnt_ext;

    always_comb begin
        gnt_o   = '0;
        found   = 1'b0;
        k       = '0;
        gnt_ext = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            k = SW'((32'(ptr_i) + i) % NUM_SRC);
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
            end
        end
        gnt_ext[NUM_SRC-1:0] = gnt_o;
        idx_o = SW'(onehot_to_idx(gnt_ext));
        any_o = |req_i;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_SRC sources in bounded bursts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned SW         = $clog2(NUM_SRC)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_t         state_q;
    logic [NUM_SRC-1:0] grant_q;
    logic [SW-1:0]      grant_id_q;
    logic [SW-1:0]      ptr_q;
    logic [CW-1:0]      cnt_q;

    logic [NUM_SRC-1:0] pick_gnt;
    logic [SW-1:0]      pick_idx;
    logic               pick_any;
    logic               busy;
    logic               beat;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SW      (SW)
    ) u_rr_pick (
        .req_i (bus.i_valid_s),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Data path hangs off registered state only, so reset clears it without a clock.
    always_comb begin
        busy          = (state_q == ARB_GRANT);
        bus.o_valid_m = busy & bus.i_valid_s[grant_id_q];
        bus.o_ready_s = busy ? (grant_q & {NUM_SRC{bus.i_ready_m}}) : '0;
        bus.o_dataout = busy ? bus.i_datain[grant_id_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        beat          = bus.o_valid_m & bus.i_ready_m;
    end

    assign bus.o_grant    = grant_q;
    assign bus.o_grant_id = grant_id_q;
    assign bus.o_busy     = busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= SW'(rr_reset_ptr(NUM_SRC));
            cnt_q      <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_any && !bus.i_almostfull) begin
                        state_q    <= ARB_GRANT;
                        grant_q    <= pick_gnt;
                        grant_id_q <= pick_idx;
                        cnt_q      <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (!bus.i_valid_s[grant_id_q] ||
                        (beat && (bus.i_last_s[grant_id_q] ||
                                  cnt_q == CW'(MAX_BURST - 1)))) begin
                        state_q <= ARB_IDLE;
                        grant_q <= '0;
                        ptr_q   <= grant_id_q;
                        cnt_q   <= '0;
                    end else if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a transaction-level ownership model.
module tb_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 4;

    logic clk;
    logic rst;

    fifo_wr_arbiter_if #(.NUM_SRC(N), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_SRC    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the port, beats it has moved, and whom the scan starts after.
    int          m_owner;
    int          m_ptr;
    int          m_beats;
    int unsigned seq [N];

    logic [N-1:0] vld, lst;
    logic         rdy, af;
    logic         prev_busy;
    int           grant_log [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_beats = 0;
    endtask

    task automatic drive_bus();
        bus.i_valid_s    = vld;
        bus.i_last_s     = lst;
        bus.i_ready_m    = rdy;
        bus.i_almostfull = af;
        for (int k = 0; k < N; k++) bus.i_datain[k*DW +: DW] = {8'(k), 24'(seq[k])};
    endtask

    task automatic pick_inputs(input int mode);
        case (mode)
            0: begin vld = '1; lst = '0; rdy = 1'b1; af = 1'b0; end
            2: begin vld = 4'b0100; lst = '0; rdy = 1'b1; af = 1'b0; end
            3: begin vld = 4'($urandom_range(1, 15)); lst = '0; rdy = 1'b1; af = 1'b1; end
            default: begin
                for (int k = 0; k < N; k++) begin
                    vld[k] = ($urandom_range(0, 3) != 0);
                    lst[k] = ($urandom_range(0, 4) == 0);
                end
                rdy = ($urandom_range(0, 3) != 0);
                af  = ($urandom_range(0, 4) == 0);
            end
        endcase
    endtask

    task automatic check_outputs();
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_rdy;
        logic          e_busy;
        logic          e_vm;
        logic [DW-1:0] e_data;
        e_gnt  = '0;
        e_busy = (m_owner >= 0);
        if (e_busy) e_gnt[m_owner] = 1'b1;
        e_rdy  = (e_busy && rdy) ? e_gnt : '0;
        e_vm   = e_busy && vld[m_owner];
        e_data = e_busy ? {8'(m_owner), 24'(seq[m_owner])} : '0;
        check_eq("busy", 64'(bus.o_busy), 64'(e_busy));
        check_eq("grant", 64'(bus.o_grant), 64'(e_gnt));
        check_eq("ready_s", 64'(bus.o_ready_s), 64'(e_rdy));
        check_eq("valid_m", 64'(bus.o_valid_m), 64'(e_vm));
        check_eq("dataout", 64'(bus.o_dataout), 64'(e_data));
        if (e_busy) check_eq("grant_id", 64'(bus.o_grant_id), 64'(m_owner));
    endtask

    task automatic model_step();
        logic found;
        int   c;
        found = 1'b0;
        if (m_owner < 0) begin
            if (!af && (|vld)) begin
                for (int i = 1; i <= N; i++) begin
                    c = (m_ptr + i) % N;
                    if (!found && vld[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                    end
                end
                m_beats = 0;
            end
        end else if (!vld[m_owner]) begin
            m_ptr   = m_owner;
            m_owner = -1;
        end else if (rdy) begin
            seq[m_owner]++;
            m_beats++;
            if (lst[m_owner] || m_beats == MB) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic run(input int mode, input int cycles);
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            pick_inputs(mode);
            drive_bus();
            #1;
            check_outputs();
            if (bus.o_busy && !prev_busy) grant_log.push_back(int'(bus.o_grant_id));
            prev_busy = bus.o_busy;
            model_step();
        end
    endtask

    task automatic quiet_inputs();
        vld = '0; lst = '0; rdy = 1'b1; af = 1'b0;
        drive_bus();
    endtask

    initial begin
        for (int k = 0; k < N; k++) seq[k] = 32'h10 * k;
        prev_busy = 1'b0;
        rst = 1'b1;
        quiet_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant", 64'(bus.o_grant), 64'h0);
        check_eq("rst_id", 64'(bus.o_grant_id), 64'h0);
        check_eq("rst_busy", 64'(bus.o_busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // All sources requesting: order 0,1,2,3,0.
        grant_log.delete();
        run(0, 30);
        check_eq("order_len", 64'(grant_log.size() >= 5), 64'h1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check_eq("order", 64'(grant_log[i]), 64'(i % N));

        // Asynchronous reset between edges while a grant is live.
        #1 rst = 1'b1;
        #1;
        check_eq("arst_busy", 64'(bus.o_busy), 64'h0);
        check_eq("arst_grant", 64'(bus.o_grant), 64'h0);
        check_eq("arst_ready", 64'(bus.o_ready_s), 64'h0);
        check_eq("arst_valid", 64'(bus.o_valid_m), 64'h0);
        check_eq("arst_data", 64'(bus.o_dataout), 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        quiet_inputs();
        prev_busy = 1'b0;
        grant_log.delete();
        run(0, 8);
        check_eq("post_rst_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'h0);

        // Lone requester, almostfull held, then mixed random traffic.
        run(2, 20);
        run(3, 10);
        run(1, 3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one sync_fifo write port among NUM_SRC valid/ready sources.
- Grants one source at a time for a bounded burst and muxes its data onto the FIFO i_valid_s/i_datain.
- Uses the FIFO's o_ready_s and o_almostfull to throttle transfers and gate new grants.
- Sits directly in front of sync_fifo in the write domain, same clock.

Parameters:
- NUM_SRC, 4, number of requesting sources (>=2)
- DATA_WIDTH, 32, data width per source and to FIFO
- MAX_BURST, 4, max beats per grant (>=1)
- SW, $clog2(NUM_SRC), grant index width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active high
- i_valid_s  in  NUM_SRC  per-source write request
- i_last_s  in  NUM_SRC  per-source end-of-packet marker, qualified by valid
- i_datain  in  NUM_SRC*DATA_WIDTH  per-source data, source k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_ready_s  out  NUM_SRC  per-source accept
- o_valid_m  out  1  to FIFO i_valid_s
- o_dataout  out  DATA_WIDTH  to FIFO i_datain
- i_ready_m  in  1  from FIFO o_ready_s (FIFO not full)
- i_almostfull  in  1  from FIFO o_almostfull
- o_grant  out  NUM_SRC  one-hot registered grant
- o_grant_id  out  SW  index of granted source
- o_busy  out  1  state == GRANT

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, on i_clk and i_rst. Reset forces:
  - state IDLE, o_grant=0, o_grant_id=0, beat count=0
  - rr pointer=NUM_SRC-1, so source 0 wins first
  - all outputs 0 immediately, without waiting for a clock edge
- Data path is combinational from the registered grant:
  - o_valid_m = busy & i_valid_s[id]
  - o_ready_s[k] = busy & o_grant[k] & i_ready_m
  - o_dataout = slice[id] when busy, else 0
- Beat = o_valid_m & i_ready_m.
- FSM IDLE:
  - Any i_valid_s and !i_almostfull → register the winner, go to GRANT, count=0.
  - Winner is the first requester scanning upward from pointer+1 with wrap.
  - Grant latency is 1 cycle from request to o_grant.
  - If i_almostfull=1, stay in IDLE; no grant is issued.
- FSM GRANT:
  - On each beat, count+1.
  - Release to IDLE on any of:
    - a beat with count==MAX_BURST-1
    - a beat with i_last_s[id]=1
    - i_valid_s[id]=0 (no beat that cycle)
  - On release: pointer=id, o_grant=0.
  - Mandatory 1 idle cycle between grants.
- i_ready_m=0 stalls: no beat, count held, grant held, and the arbiter imposes no timeout.
- i_almostfull has no effect inside GRANT; the burst completes under i_ready_m control.
- Fairness:
  - With all sources requesting, grant order is 0,1,...,NUM_SRC-1,0.
  - A lone requester is re-granted after the idle cycle.
- Counter width: $clog2(MAX_BURST+1). It never exceeds MAX_BURST-1 in GRANT.
- i_valid_s/i_last_s of non-granted sources are ignored; their o_ready_s is 0.
- Reset mid-burst: the in-flight beat is dropped; the source sees o_ready_s=0.

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT}
  - onehot-to-index function
  - rr_next(pointer, req) function prototype constants
- Sub-module rr_pick:
  - purely combinational round-robin picker
  - inputs req[NUM_SRC], pointer[SW]
  - outputs onehot winner, winner index, any_req
- fifo_wr_arbiter holds the FSM, counter, pointer and data mux.

Test Plan (NUM_SRC=4, DATA_WIDTH=32, MAX_BURST=4, sync_fifo depth 8 as sink):
- Reset, then all 4 sources valid continuously, i_ready_m=1, last=0:
  - grants 0,1,2,3,0 in order, 4 beats each, 1 idle cycle between
  - FIFO receives data in source order
- Only source 2 valid, data 0xA0,0xA1,...:
  - 4 beats 0xA0-0xA3
  - o_busy low 1 cycle
  - regrant to 2, next beat 0xA4
- Source 1 sends 2 beats with i_last_s on beat 2, source 3 also valid:
  - release after beat 2
  - next grant is source 3, not source 0
- i_almostfull=1 held in IDLE with requests for 5 cycles:
  - o_grant stays 0
- i_almostfull rising during a grant:
  - burst completes all 4 beats
  - no new grant until almostfull drops
- i_ready_m=0 for 3 cycles after beat 1:
  - o_ready_s=0, o_valid_m=1, o_dataout stable
  - count held; the remaining 3 beats follow when ready returns
- i_rst pulse mid-burst between clock edges:
  - all outputs 0 before next edge
  - after release, first grant goes to source 0
